mem_req_master: RTL and testbench

//  Initiator side of the memory read/write/permission protocol. Accepts one command
//  at a time from the core's load/store stage and drives a single read port, the

---
 rtl/mem_req_pkg.sv | 28 ++
 rtl/mem_req_timer.sv | 51 +++++
 rtl/mem_req_master.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_req_master.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// mem_req_pkg
//   Shared encodings for the memory request initiator: command opcodes,
//   response status codes and the FSM state set.
package mem_req_pkg;

   typedef enum logic [1:0] {
      OP_RD   = 2'd0,
      OP_WR   = 2'd1,
      OP_PERM = 2'd2,
      OP_RSVD = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_OK       = 2'd0,
      ST_PERM_ERR = 2'd1,
      ST_TIMEOUT  = 2'd2,
      ST_BAD_OP   = 2'd3
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_WR    = 3'd2,
      S_PERM  = 3'd3,
      S_DRAIN = 3'd4
   } state_e;

endpackage

// File: rtl/mem_req_timer.sv
// mem_req_timer
//   Wait-for-ack watchdog. Counts cycles while en is high and flags expired
//   once the count reaches TIMEOUT_CYC. TIMEOUT_CYC=0 disables it entirely.
// Ports
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset
//   clr      in  restart the count at zero (takes priority over en)
//   en       in  count this cycle
//   expired  out count has reached TIMEOUT_CYC
module mem_req_timer #(
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   generate
      if (TIMEOUT_CYC == 0) begin : g_off
         logic unused_timer_inputs;
         assign unused_timer_inputs = ^{clk, rst, clr, en};
         assign expired = 1'b0;
      end else begin : g_on
         localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
         logic [CW-1:0] count_q, count_d;

         // Saturates at the limit so a long stall never wraps back to "fresh".
         always_comb begin
            count_d = count_q;
            if (clr) begin
               count_d = '0;
            end else if (en && (count_q != CW'(TIMEOUT_CYC))) begin
               count_d = count_q + 1'b1;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               count_q <= '0;
            end else begin
               count_q <= count_d;
            end
         end

         assign expired = (count_q == CW'(TIMEOUT_CYC));
      end
   endgenerate

endmodule

// File: rtl/mem_req_master.sv
// mem_req_master
//   Initiator for the memory read / write / permission protocol. Takes one
//   command at a time from the load/store stage, drives the read, write or
//   permission port, and returns a one-cycle response with status and data.
//   All outputs come straight from flops.
// Ports
//   clk, rst                         clock; asynchronous active-high reset
//   cmd_valid/ready/op/addr/addr_end/wdata   command channel (ready only in IDLE)
//   rsp_valid/status/rdata           one-cycle response pulse, no backpressure
//   rd_req/rd_addr, rd_ack/rd_data   read port (req held until ack or timeout)
//   wr_req/wr_addr/wr_data, wr_ack/wr_perm_err   write port
//   perm_req/perm_start/perm_end     one-cycle read-only region programming
module mem_req_master
   import mem_req_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_end,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [1:0]            rsp_status,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rd_req,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_ack,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  wr_req,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_ack,
   input  logic                  wr_perm_err,
   output logic                  perm_req,
   output logic [ADDR_WIDTH-1:0] perm_start,
   output logic [ADDR_WIDTH-1:0] perm_end
);

   state_e                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   status_e               rsp_status_q, rsp_status_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rd_req_q, rd_req_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  wr_req_q, wr_req_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  perm_req_q, perm_req_d;
   logic [ADDR_WIDTH-1:0] perm_start_q, perm_start_d;
   logic [ADDR_WIDTH-1:0] perm_end_q, perm_end_d;
   logic                  timer_clr, timer_en, timer_expired;

   mem_req_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = 1'b0;
      rsp_valid_d  = 1'b0;
      rsp_status_d = ST_OK;
      rsp_rdata_d  = '0;
      rd_req_d     = rd_req_q;
      rd_addr_d    = rd_addr_q;
      wr_req_d     = wr_req_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      perm_req_d   = 1'b0;
      perm_start_d = perm_start_q;
      perm_end_d   = perm_end_q;
      timer_clr    = 1'b0;
      timer_en     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            // Accept only against the registered ready the core actually saw.
            if (cmd_valid && cmd_ready_q) begin
               case (op_e'(cmd_op))
                  OP_RD: begin
                     state_d     = S_RD;
                     cmd_ready_d = 1'b0;
                     rd_req_d    = 1'b1;
                     rd_addr_d   = cmd_addr;
                     timer_clr   = 1'b1;
                  end
                  OP_WR: begin
                     state_d     = S_WR;
                     cmd_ready_d = 1'b0;
                     wr_req_d    = 1'b1;
                     wr_addr_d   = cmd_addr;
                     wr_data_d   = cmd_wdata;
                     timer_clr   = 1'b1;
                  end
                  OP_PERM: begin
                     state_d      = S_PERM;
                     cmd_ready_d  = 1'b0;
                     perm_req_d   = 1'b1;
                     perm_start_d = cmd_addr;
                     perm_end_d   = cmd_addr_end;
                  end
                  OP_RSVD: begin
                     rsp_valid_d  = 1'b1;
                     rsp_status_d = ST_BAD_OP;
                  end
               endcase
            end
         end

         S_RD: begin
            // Ack beats the timeout when both land in the same cycle.
            if (rd_ack) begin
               rsp_valid_d  = 1'b1;
               rsp_rdata_d  = rd_data;
               rd_req_d     = 1'b0;
               state_d      = S_DRAIN;
            end else if (timer_expired) begin
               rsp_valid_d  = 1'b1;
               rsp_status_d = ST_TIMEOUT;
               rd_req_d     = 1'b0;
               state_d      = S_DRAIN;
            end else begin
               timer_en = 1'b1;
            end
         end

         S_WR: begin
            if (wr_ack) begin
               rsp_valid_d  = 1'b1;
               rsp_status_d = wr_perm_err ? ST_PERM_ERR : ST_OK;
               wr_req_d     = 1'b0;
               state_d      = S_DRAIN;
            end else if (timer_expired) begin
               rsp_valid_d  = 1'b1;
               rsp_status_d = ST_TIMEOUT;
               wr_req_d     = 1'b0;
               state_d      = S_DRAIN;
            end else begin
               timer_en = 1'b1;
            end
         end

         S_PERM: begin
            // No ack on the permission port; the pulse is the whole transaction.
            rsp_valid_d = 1'b1;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
         end

         S_DRAIN: begin
            // Hold off new commands until the memory has released both acks,
            // otherwise a lingering ack would complete the next request early.
            if (!rd_ack && !wr_ack) begin
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cmd_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= ST_OK;
         rsp_rdata_q  <= '0;
         rd_req_q     <= 1'b0;
         rd_addr_q    <= '0;
         wr_req_q     <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         perm_req_q   <= 1'b0;
         perm_start_q <= '0;
         perm_end_q   <= '0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_status_q <= rsp_status_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rd_req_q     <= rd_req_d;
         rd_addr_q    <= rd_addr_d;
         wr_req_q     <= wr_req_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         perm_req_q   <= perm_req_d;
         perm_start_q <= perm_start_d;
         perm_end_q   <= perm_end_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_status = rsp_status_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rd_req     = rd_req_q;
   assign rd_addr    = rd_addr_q;
   assign wr_req     = wr_req_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign perm_req   = perm_req_q;
   assign perm_start = perm_start_q;
   assign perm_end   = perm_end_q;

endmodule

// File: tb/tb_mem_req_master.sv
// tb_mem_req_master
//   Drives mem_req_master with directed and randomized commands against a
//   behavioural memory responder, and compares each response with a
//   command-level reference model of memory contents and the read-only region.
`timescale 1ns/1ps
module tb_mem_req_master;
   import mem_req_pkg::*;

   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int TMO   = 15;
   localparam int LIMIT = 60;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr, cmd_addr_end;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [1:0]    rsp_status;
   logic [DW-1:0] rsp_rdata;
   logic          rd_req, rd_ack;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          wr_req, wr_ack, wr_perm_err;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          perm_req;
   logic [AW-1:0] perm_start, perm_end;

   always #5 clk = ~clk;

   mem_req_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_addr_end(cmd_addr_end), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_perm_err(wr_perm_err),
      .perm_req(perm_req), .perm_start(perm_start), .perm_end(perm_end)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int n_txn = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] init_val(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
   endfunction

   // ---------------- memory responder (environment) ----------------
   bit            no_ack;
   int            extra_hold;
   logic [15:0]   mem [65536];
   bit            mem_wr [65536];
   bit            ro_valid;
   bit [15:0]     ro_s, ro_e;
   int            rd_hold, wr_hold;

   function automatic logic [15:0] resp_mem(input logic [15:0] a);
      return mem_wr[a] ? mem[a] : init_val(a);
   endfunction

   function automatic bit resp_ro(input logic [15:0] a);
      return ro_valid && (a >= ro_s) && (a <= ro_e);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ack <= 1'b0; rd_data <= '0; rd_hold <= 0;
         wr_ack <= 1'b0; wr_perm_err <= 1'b0; wr_hold <= 0;
      end else begin
         if (perm_req) begin
            ro_valid <= 1'b1; ro_s <= perm_start; ro_e <= perm_end;
         end
         if (rd_req && !no_ack) begin
            rd_ack <= 1'b1; rd_data <= resp_mem(rd_addr); rd_hold <= extra_hold;
         end else if (rd_ack && rd_hold > 0) begin
            rd_hold <= rd_hold - 1;
         end else begin
            rd_ack <= 1'b0; rd_data <= 16'($urandom);
         end
         if (wr_req && !no_ack) begin
            wr_ack <= 1'b1; wr_hold <= extra_hold;
            if (!wr_ack) begin
               wr_perm_err <= resp_ro(wr_addr);
               if (!resp_ro(wr_addr)) begin
                  mem[wr_addr] <= wr_data; mem_wr[wr_addr] <= 1'b1;
               end
            end
         end else if (wr_ack && wr_hold > 0) begin
            wr_hold <= wr_hold - 1;
         end else begin
            wr_ack <= 1'b0; wr_perm_err <= 1'b0;
         end
      end
   end

   // ---------------- reference model (command level) ----------------
   logic [15:0] ref_mem [65536];
   bit          ref_wr [65536];
   bit          ref_ro_valid;
   bit [15:0]   ref_ro_s, ref_ro_e;

   function automatic logic [15:0] model_rd(input logic [15:0] a);
      return ref_wr[a] ? ref_mem[a] : init_val(a);
   endfunction

   function automatic bit model_ro(input logic [15:0] a);
      return ref_ro_valid && (a >= ref_ro_s) && (a <= ref_ro_e);
   endfunction

   task automatic run_cmd(input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] ae, input logic [15:0] wd);
      int rsp_k, rdy_k, n_rsp, n_rd, n_wr, n_pm, w;
      logic [1:0]  got_st, exp_st;
      logic [15:0] got_rd, exp_rd;
      int exp_lat, exp_rdy, exp_nrd, exp_nwr, exp_npm;

      exp_rd = '0; exp_nrd = 0; exp_nwr = 0; exp_npm = 0;
      exp_st = ST_OK; exp_lat = 0; exp_rdy = 0;
      case (op)
         2'd0, 2'd1: begin
            if (no_ack) begin
               exp_st = ST_TIMEOUT; exp_lat = TMO + 1; exp_rdy = TMO + 2;
            end else begin
               exp_lat = 2; exp_rdy = 4 + extra_hold;
               if (op == 2'd0) begin
                  exp_rd = model_rd(a);
               end else if (model_ro(a)) begin
                  exp_st = ST_PERM_ERR;
               end else begin
                  ref_mem[a] = wd; ref_wr[a] = 1'b1;
               end
            end
            if (op == 2'd0) exp_nrd = exp_lat; else exp_nwr = exp_lat;
         end
         2'd2: begin
            ref_ro_valid = 1'b1; ref_ro_s = a; ref_ro_e = ae;
            exp_lat = 1; exp_rdy = 1; exp_npm = 1;
         end
         default: begin
            exp_st = ST_BAD_OP;
         end
      endcase

      w = 0;
      while (cmd_ready !== 1'b1 && w < LIMIT) begin
         @(negedge clk); w++;
      end
      check_eq("ready_before_cmd", cmd_ready, 1'b1);

      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_addr_end = ae; cmd_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'($urandom);
      cmd_addr = 16'($urandom); cmd_addr_end = 16'($urandom); cmd_wdata = 16'($urandom);

      case (op)
         2'd0: check_eq("rd_addr", rd_addr, a);
         2'd1: begin check_eq("wr_addr", wr_addr, a); check_eq("wr_data", wr_data, wd); end
         2'd2: begin check_eq("perm_start", perm_start, a); check_eq("perm_end", perm_end, ae); end
         default: ;
      endcase

      rsp_k = -1; rdy_k = -1; n_rsp = 0; n_rd = 0; n_wr = 0; n_pm = 0;
      got_st = 2'b00; got_rd = '0;
      for (int k = 0; k < LIMIT; k++) begin
         if (k > 0) @(negedge clk);
         if (rsp_valid) begin
            n_rsp++;
            if (rsp_k < 0) begin rsp_k = k; got_st = rsp_status; got_rd = rsp_rdata; end
         end
         n_rd += int'(rd_req); n_wr += int'(wr_req); n_pm += int'(perm_req);
         if (cmd_ready) begin rdy_k = k; break; end
      end
      @(negedge clk);
      if (rsp_valid) n_rsp++;

      check_eq("rsp_status", got_st, exp_st);
      check_eq("rsp_rdata", got_rd, exp_rd);
      check_eq("rsp_latency", rsp_k, exp_lat);
      check_eq("ready_latency", rdy_k, exp_rdy);
      check_eq("rsp_pulses", n_rsp, 1);
      check_eq("rd_req_cycles", n_rd, exp_nrd);
      check_eq("wr_req_cycles", n_wr, exp_nwr);
      check_eq("perm_req_cycles", n_pm, exp_npm);
      if (op == 2'd1) check_eq("mem_after_wr", resp_mem(a), model_rd(a));

      n_txn++;
      $display("txn %0d op=%0d addr=%04h end=%04h wdata=%04h no_ack=%0d hold=%0d -> status=%0d rdata=%04h rsp_lat=%0d ready_lat=%0d",
               n_txn, op, a, ae, wd, no_ack, extra_hold, got_st, got_rd, rsp_k, rdy_k);
   endtask

   task automatic rst_mid_write(input logic [15:0] a, input logic [15:0] wd);
      int nr;
      nr = 0;
      check_eq("ready_before_rst_wr", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = a; cmd_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq("wr_req_before_rst", wr_req, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("wr_req_async_drop", wr_req, 1'b0);
      check_eq("ready_in_rst", cmd_ready, 1'b0);
      repeat (2) begin @(negedge clk); nr += int'(rsp_valid); end
      rst = 1'b0;
      @(negedge clk);
      nr += int'(rsp_valid);
      check_eq("ready_after_rst_release", cmd_ready, 1'b1);
      repeat (4) begin @(negedge clk); nr += int'(rsp_valid); end
      check_eq("no_rsp_after_rst", nr, 0);
      check_eq("mem_after_aborted_wr", resp_mem(a), model_rd(a));
      n_txn++;
      $display("txn %0d rst during write addr=%04h wdata=%04h -> responses=%0d", n_txn, a, wd, nr);
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 6))
         0: return ref_ro_s;
         1: return ref_ro_e;
         2: return ref_ro_s - 16'd1;
         3: return ref_ro_e + 16'd1;
         4: return 16'h0010;
         5: return 16'h0200;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  op;
      logic [15:0] a, ae;
      int r;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_addr_end = '0; cmd_wdata = '0;
      no_ack = 1'b0; extra_hold = 0;
      repeat (2) @(negedge clk);
      check_eq("rst_ready", cmd_ready, 1'b0);
      check_eq("rst_reqs", {rsp_valid, rd_req, wr_req, perm_req}, 4'b0);
      check_eq("rst_rsp", {rsp_status, rsp_rdata}, 18'b0);
      check_eq("rst_addrs", {rd_addr, wr_addr}, 32'b0);
      check_eq("rst_perm", {perm_start, perm_end}, 32'b0);
      check_eq("rst_wdata", wr_data, 16'b0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("ready_after_rst", cmd_ready, 1'b1);

      // Zero-wait read of preloaded data.
      run_cmd(2'd0, 16'h0010, 16'h0, 16'h0);
      // Read-only region then writes inside, on its edges, and outside.
      run_cmd(2'd2, 16'h0100, 16'h01FF, 16'h0);
      run_cmd(2'd1, 16'h0150, 16'h0, 16'h1234);
      run_cmd(2'd1, 16'h0100, 16'h0, 16'h1111);
      run_cmd(2'd1, 16'h01FF, 16'h0, 16'h2222);
      run_cmd(2'd1, 16'h00FF, 16'h0, 16'h3333);
      run_cmd(2'd1, 16'h0200, 16'h0, 16'h1234);
      run_cmd(2'd0, 16'h0150, 16'h0, 16'h0);
      run_cmd(2'd0, 16'h0200, 16'h0, 16'h0);
      // Responder never acks.
      no_ack = 1'b1;
      run_cmd(2'd0, 16'h0010, 16'h0, 16'h0);
      run_cmd(2'd1, 16'h0300, 16'h0, 16'h5555);
      no_ack = 1'b0;
      // Ack lingers after req drops; following read must get its own data.
      extra_hold = 3;
      run_cmd(2'd0, 16'h0010, 16'h0, 16'h0);
      extra_hold = 0;
      run_cmd(2'd0, 16'h0200, 16'h0, 16'h0);
      // Reserved opcode, then an inverted permission range.
      run_cmd(2'd3, 16'h0042, 16'h0, 16'h0);
      run_cmd(2'd2, 16'h0400, 16'h0300, 16'h0);
      run_cmd(2'd1, 16'h0350, 16'h0, 16'h7777);
      // Reset while a write is outstanding.
      rst_mid_write(16'h0600, 16'hCAFE);
      run_cmd(2'd0, 16'h0600, 16'h0, 16'h0);

      for (int i = 0; i < 80; i++) begin
         no_ack     = ($urandom_range(0, 7) == 0);
         extra_hold = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         a  = pick_addr();
         ae = pick_addr();
         if (op == 2'd2) begin
            case ($urandom_range(0, 3))
               0: begin a = 16'h0100; ae = 16'h01FF; end
               1: begin a = 16'h01FF; ae = 16'h0100; end
               2: ae = a;
               default: ;
            endcase
         end
         run_cmd(op, a, ae, 16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
